// File: rtl/sgd_rd_x_pkg.sv
// sgd_rd_x_pkg: shared sgd defines plus loader FSM state and sizing helpers.
// Optional build macro SGD_RD_X_STATE_CNT_EN enables the accepted-beat counter.
`ifndef SGD_DEFINES
`define SGD_DEFINES
`define ENGINE_NUM 8
`define NUM_BITS_PER_BANK 2048
`define DIS_X_BIT_DEPTH 9
`endif

package sgd_rd_x_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_x_state_e;

  localparam int BEAT_W         = 512;
  localparam int BEATS_PER_WORD = 4;
  localparam int FEAT_PER_WORD  = 64;
  localparam int BYTES_PER_WORD = 256;

  // ceil(dim / (engines*64)) without overflowing near 2^32
  function automatic logic [31:0] rows_for(
    input logic [31:0] dim,
    input int unsigned engines
  );
    logic [31:0] per;
    per = 32'(engines * 32'(FEAT_PER_WORD));
    return dim / per + {31'd0, |(dim % per)};
  endfunction

endpackage

// File: rtl/sgd_x_beat_assembler.sv
// sgd_x_beat_assembler: packs four 512-bit beats into one bank word
// and emits a one-hot bank write the cycle after the fourth beat.
module sgd_x_beat_assembler
  import sgd_rd_x_pkg::*;
#(
  parameter int ENGINE_NUM   = `ENGINE_NUM,
  parameter int BANK_WIDTH   = `NUM_BITS_PER_BANK,
  parameter int X_ADDR_WIDTH = `DIS_X_BIT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    beat_valid,
  input  logic [BEAT_W-1:0]       beat_data,
  output logic [X_ADDR_WIDTH-1:0] wr_addr,
  output logic [BANK_WIDTH-1:0]   wr_data,
  output logic [ENGINE_NUM-1:0]   wr_en
);

  localparam int EW = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;

  logic [1:0]              inner;
  logic [EW-1:0]           engine;
  logic [X_ADDR_WIDTH-1:0] row;
  logic [BANK_WIDTH-1:0]   word_q;
  logic                    last_inner;

  assign last_inner = inner == 2'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner   <= '0;
      engine  <= '0;
      row     <= '0;
      wr_en   <= '0;
      wr_addr <= '0;
    end else begin
      wr_en <= '0;
      if (clear) begin
        inner  <= '0;
        engine <= '0;
        row    <= '0;
      end else if (beat_valid) begin
        inner <= inner + 2'd1;
        if (last_inner) begin
          wr_en   <= ENGINE_NUM'(1) << engine;
          wr_addr <= row;
          if (engine == EW'(ENGINE_NUM - 1)) begin
            engine <= '0;
            row    <= row + X_ADDR_WIDTH'(1);
          end else begin
            engine <= engine + EW'(1);
          end
        end
      end
    end
  end

  // Word storage is wide and needs no reset; the output is gated instead.
  always_ff @(posedge clk) begin
    if (beat_valid && !clear)
      word_q[32'(inner)*BEAT_W +: BEAT_W] <= beat_data;
  end

  assign wr_data = (|wr_en) ? word_q : '0;

endmodule

// File: rtl/sgd_rd_x_from_memory.sv
// sgd_rd_x_from_memory: loads the x vector from host memory into the banks.
// Optional build macro SGD_RD_X_STATE_CNT_EN enables the debug beat counter.
module sgd_rd_x_from_memory
  import sgd_rd_x_pkg::*;
#(
  parameter int ENGINE_NUM   = `ENGINE_NUM,
  parameter int BANK_WIDTH   = `NUM_BITS_PER_BANK,
  parameter int X_ADDR_WIDTH = `DIS_X_BIT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    started,
  input  logic [63:0]             addr_model,
  input  logic [31:0]             dimension,
  input  logic                    reading_x_from_host_memory_en,
  output logic                    reading_x_from_host_memory_done,
  output logic                    x_data_rd_start,
  output logic [63:0]             x_data_rd_addr,
  output logic [31:0]             x_data_rd_length,
  input  logic [511:0]            x_data_in,
  input  logic                    x_data_in_valid,
  output logic                    x_data_in_ready,
  output logic [X_ADDR_WIDTH-1:0] x_mem_wr_addr,
  output logic [BANK_WIDTH-1:0]   x_mem_wr_data,
  output logic [ENGINE_NUM-1:0]   x_mem_wr_en,
  output logic [31:0]             state_counters_rd_x_from_memory
);

  localparam logic [31:0] ROW_BEATS = 32'(ENGINE_NUM * BEATS_PER_WORD);
  localparam logic [31:0] ROW_BYTES = 32'(ENGINE_NUM * BYTES_PER_WORD);

  rd_x_state_e state;
  logic        en_q;
  logic [31:0] rows_c;
  logic [31:0] beats;
  logic [31:0] beat_cnt;
  logic        rise;
  logic        accept;
  logic        asm_clear;

  assign rows_c    = rows_for(dimension, ENGINE_NUM);
  assign rise      = reading_x_from_host_memory_en & ~en_q;
  assign accept    = x_data_in_valid & x_data_in_ready;
  assign asm_clear = ~started | (state != DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                           <= IDLE;
      en_q                            <= 1'b0;
      beats                           <= '0;
      beat_cnt                        <= '0;
      x_data_rd_start                 <= 1'b0;
      x_data_rd_addr                  <= '0;
      x_data_rd_length                <= '0;
      x_data_in_ready                 <= 1'b0;
      reading_x_from_host_memory_done <= 1'b0;
    end else begin
      en_q                            <= reading_x_from_host_memory_en;
      x_data_rd_start                 <= 1'b0;
      reading_x_from_host_memory_done <= 1'b0;
      if (!started) begin
        state           <= IDLE;
        x_data_in_ready <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (rise) begin
            state            <= CMD;
            beats            <= rows_c * ROW_BEATS;
            beat_cnt         <= '0;
            x_data_rd_start  <= rows_c != '0;
            x_data_rd_addr   <= addr_model;
            x_data_rd_length <= rows_c * ROW_BYTES;
          end
          CMD: begin
            if (beats == '0) begin
              state <= DONE;
            end else begin
              state           <= DATA;
              x_data_in_ready <= 1'b1;
            end
          end
          DATA: if (accept) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (beat_cnt == beats - 32'd1) begin
              state           <= DONE;
              x_data_in_ready <= 1'b0;
            end
          end
          DONE: begin
            state                           <= IDLE;
            reading_x_from_host_memory_done <= 1'b1;
          end
        endcase
      end
    end
  end

  sgd_x_beat_assembler #(
    .ENGINE_NUM  (ENGINE_NUM),
    .BANK_WIDTH  (BANK_WIDTH),
    .X_ADDR_WIDTH(X_ADDR_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .beat_valid(accept),
    .beat_data (x_data_in),
    .wr_addr   (x_mem_wr_addr),
    .wr_data   (x_mem_wr_data),
    .wr_en     (x_mem_wr_en)
  );

`ifdef SGD_RD_X_STATE_CNT_EN
  logic [31:0] beat_total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_total <= '0;
    else if (accept && beat_total != 32'hFFFF_FFFF)
      beat_total <= beat_total + 32'd1;
  end

  assign state_counters_rd_x_from_memory = beat_total;
`else
  assign state_counters_rd_x_from_memory = '0;
`endif

endmodule

// File: tb/tb_sgd_rd_x_from_memory.sv
// tb_sgd_rd_x_from_memory: scoreboard bench for the x loader,
// expected bank writes queued as beats are driven, popped on each write.
module tb_sgd_rd_x_from_memory;

  localparam int EN = 8;
  localparam int BW = 2048;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          started = 1'b0;
  logic [63:0]   addr_model = '0;
  logic [31:0]   dimension = '0;
  logic          en = 1'b0;
  logic          done;
  logic          rd_start;
  logic [63:0]   rd_addr;
  logic [31:0]   rd_len;
  logic [511:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_data;
  logic [EN-1:0] wr_en;
  logic [31:0]   st_cnt;

  sgd_rd_x_from_memory #(
    .ENGINE_NUM(EN), .BANK_WIDTH(BW), .X_ADDR_WIDTH(AW)
  ) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .started                        (started),
    .addr_model                     (addr_model),
    .dimension                      (dimension),
    .reading_x_from_host_memory_en  (en),
    .reading_x_from_host_memory_done(done),
    .x_data_rd_start                (rd_start),
    .x_data_rd_addr                 (rd_addr),
    .x_data_rd_length               (rd_len),
    .x_data_in                      (din),
    .x_data_in_valid                (din_valid),
    .x_data_in_ready                (din_ready),
    .x_mem_wr_addr                  (wr_addr),
    .x_mem_wr_data                  (wr_data),
    .x_mem_wr_en                    (wr_en),
    .state_counters_rd_x_from_memory(st_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EN-1:0] en;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  wr_t         sbq[$];
  wr_t         mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          n_start = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  int          exp_cnt = 0;
  logic [63:0] st_addr = '0;
  logic [31:0] st_len = '0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] beat(int seed, int k);
    logic [511:0] b;
    for (int i = 0; i < 16; i++)
      b[i*32 +: 32] = {8'(seed), 12'(k), 12'(i)};
    return b;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en != '0) begin
        n_wr++;
        last_wr_cyc = cyc;
        check("wr_onehot", 64'($onehot(wr_en)), 64'd1);
        if (sbq.size() == 0) begin
          check("wr_unexpected", 64'(wr_en), 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("wr_en", 64'(wr_en), 64'(mon_e.en));
          check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
          for (int i = 0; i < BW/64; i++)
            check("wr_data", wr_data[i*64 +: 64], mon_e.data[i*64 +: 64]);
        end
      end
      if (rd_start) begin
        n_start++;
        st_addr = rd_addr;
        st_len  = rd_len;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic send(int n, bit gaps, int seed);
    int k = 0;
    int pushed = -1;
    int guard = 0;
    bit rdy = 1'b0;
    logic [BW-1:0] asm_m = '0;
    wr_t e;
    while (k < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (din_valid && rdy) begin
        k++;
        exp_cnt++;
      end
      rdy = din_ready;
      if (k < n) begin
        if (pushed < k) begin
          asm_m[(k%4)*512 +: 512] = beat(seed, k);
          if (k % 4 == 3) begin
            e.en   = EN'(1) << ((k/4) % EN);
            e.addr = AW'(k / (4*EN));
            e.data = asm_m;
            sbq.push_back(e);
          end
          pushed = k;
        end
        din       = beat(seed, k);
        din_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
      end else begin
        din_valid = 1'b0;
      end
    end
    if (k < n) begin
      din_valid = 1'b0;
      check("send_timeout", 64'(k), 64'(n));
    end
  endtask

  task automatic check_cnt(string tag);
`ifdef SGD_RD_X_STATE_CNT_EN
    check(tag, 64'(st_cnt), 64'(exp_cnt));
`else
    check(tag, 64'(st_cnt), 64'd0);
`endif
  endtask

  task automatic run_load(logic [31:0] dim, logic [63:0] addr, int seed,
                          bit gaps, int exp_len);
    int w0 = n_wr;
    int d0 = n_done;
    int s0 = n_start;
    int nb = exp_len / 64;
    int g = 0;
    dimension  = dim;
    addr_model = addr;
    @(negedge clk);
    en = 1'b1;
    send(nb, gaps, seed);
    while (n_done == d0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("start_cnt", 64'(n_start - s0), 64'd1);
    check("rd_addr", st_addr, addr);
    check("rd_len", 64'(st_len), 64'(exp_len));
    check("wr_cnt", 64'(n_wr - w0), 64'(nb / 4));
    check("done_cnt", 64'(n_done - d0), 64'd1);
    check("done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);
    check("sb_drain", 64'(sbq.size()), 64'd0);
    check_cnt("state_cnt");
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_data"}, wr_data[63:0], 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_start"}, 64'(rd_start), 64'd0);
    check({tag, "_ready"}, 64'(din_ready), 64'd0);
    check({tag, "_addr"}, rd_addr, 64'd0);
    check({tag, "_len"}, 64'(rd_len), 64'd0);
    check({tag, "_cnt"}, 64'(st_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, d0, w0, s0, g;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    started = 1'b1;
    repeat (2) @(negedge clk);

    run_load(32'd512, 64'h0, 1, 1'b0, 2048);
    run_load(32'd1000, 64'h1000, 2, 1'b0, 4096);

    // dimension 0: no command, no writes, done 3 cycles after the edge
    dimension = 32'd0;
    d0 = n_done;
    w0 = n_wr;
    s0 = n_start;
    @(negedge clk);
    en = 1'b1;
    c0 = cyc;
    g = 0;
    while (n_done == d0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("dim0_lat", 64'(done_cyc - c0), 64'd3);
    check("dim0_done", 64'(n_done - d0), 64'd1);
    check("dim0_start", 64'(n_start - s0), 64'd0);
    check("dim0_wr", 64'(n_wr - w0), 64'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    run_load(32'd512, 64'h0, 1, 1'b1, 2048);

    // reset after beat 10
    dimension  = 32'd512;
    addr_model = 64'h2000;
    @(negedge clk);
    en = 1'b1;
    send(10, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    sbq.delete();
    exp_cnt = 0;
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_load(32'd512, 64'h40, 4, 1'b0, 2048);

    // started dropped mid-DATA
    dimension = 32'd512;
    @(negedge clk);
    en = 1'b1;
    send(6, 1'b0, 5);
    started = 1'b0;
    sbq.delete();
    d0 = n_done;
    w0 = n_wr;
    @(negedge clk);
    check("drop_ready", 64'(din_ready), 64'd0);
    repeat (5) @(negedge clk);
    check("drop_done", 64'(n_done - d0), 64'd0);
    check("drop_wr", 64'(n_wr - w0), 64'd0);
    started = 1'b1;
    en = 1'b0;
    repeat (2) @(negedge clk);
    run_load(32'd512, 64'h80, 6, 1'b1, 2048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
